leg4_fetch_decode: RTL and testbench

//  Instruction fetch/decode sequencer for LEG4; producer side of the ALU op interface.

---
 rtl/leg4_fetch_decode_pkg.sv | 41 ++++
 rtl/leg4_fetch_decode_if.sv | 25 ++
 rtl/leg4_jcn_cond.sv | 26 ++
 rtl/leg4_fetch_decode.sv | 151 +++++++++++++++
 tb/tb_leg4_fetch_decode.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/leg4_fetch_decode_pkg.sv
// Shared definitions for the LEG4 fetch/decode sequencer.
//  - OPR (opcode group) constants, including the 0xE/0xF groups whose OPA is a subcode.
//  - FSM state encoding.
//  - is_two_byte(): decides from the first byte whether a second byte follows.
package leg4_fetch_decode_pkg;

  localparam logic [3:0] OprNop = 4'h0;
  localparam logic [3:0] OprJcn = 4'h1;
  localparam logic [3:0] OprFim = 4'h2;  // OPA[0]=1 is SRC, a 1-byte op
  localparam logic [3:0] OprFin = 4'h3;  // OPA[0]=1 is JIN
  localparam logic [3:0] OprJun = 4'h4;
  localparam logic [3:0] OprJms = 4'h5;
  localparam logic [3:0] OprInc = 4'h6;
  localparam logic [3:0] OprIsz = 4'h7;
  localparam logic [3:0] OprAdd = 4'h8;
  localparam logic [3:0] OprSub = 4'h9;
  localparam logic [3:0] OprLd  = 4'hA;
  localparam logic [3:0] OprXch = 4'hB;
  localparam logic [3:0] OprBbl = 4'hC;
  localparam logic [3:0] OprLdm = 4'hD;
  localparam logic [3:0] OprIo  = 4'hE;
  localparam logic [3:0] OprAcc = 4'hF;

  typedef enum logic [1:0] {
    StF1 = 2'd0,
    StF2 = 2'd1,
    StEx = 2'd2
  } state_e;

  function automatic logic is_two_byte(input logic [7:0] b1);
    logic two;
    two = 1'b0;
    case (b1[7:4])
      OprJcn, OprJun, OprJms, OprIsz: two = 1'b1;
      OprFim:                         two = ~b1[0];
      default:                        two = 1'b0;
    endcase
    return two;
  endfunction

endpackage

// File: rtl/leg4_fetch_decode_if.sv
// ROM fetch handshake plus the decoded-op bundle presented to the ALU.
//  master: the fetch/decode sequencer (drives rom_req and the op bundle).
//  slave : the ROM/ALU side (drives rom_ack/rom_data, consumes the op bundle).
interface leg4_fetch_decode_if;
  import leg4_fetch_decode_pkg::*;

  logic       rom_req;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic [3:0] alu_op;
  logic [3:0] opa;
  logic [7:0] byte2;
  logic       exec_valid;

  modport master (
    output rom_req, alu_op, opa, byte2, exec_valid,
    input  rom_ack, rom_data
  );

  modport slave (
    input  rom_req, alu_op, opa, byte2, exec_valid,
    output rom_ack, rom_data
  );

endinterface

// File: rtl/leg4_jcn_cond.sv
// Combinational JCN condition evaluator.
//  opa      : JCN condition nibble; [3] inverts, [2] acc_zero, [1] carry, [0] TEST pin
//  acc_zero : ACC==0
//  carry    : carry flag
//  test_n   : raw TEST pin
//  take     : 1 when the jump is taken
module leg4_jcn_cond #(
  parameter bit TEST_ACT_LO = 1'b1
) (
  input  logic [3:0] opa,
  input  logic       acc_zero,
  input  logic       carry,
  input  logic       test_n,
  output logic       take
);

  logic test_act;
  logic cond;

  always_comb begin
    test_act = TEST_ACT_LO ? ~test_n : test_n;
    cond     = (opa[2] & acc_zero) | (opa[1] & carry) | (opa[0] & test_act);
    take     = opa[3] ^ cond;
  end

endmodule

// File: rtl/leg4_fetch_decode.sv
// LEG4 instruction fetch/decode sequencer.
//  clk, rst   : rising-edge clock, synchronous active-high reset
//  bus        : ROM req/ack fetch and the alu_op/opa/byte2/exec_valid bundle (master side)
//  pc         : current PC, already past the last fetched byte
//  acc_zero, carry, test_n, reg_inc_nz, pair_val : branch inputs, used in the strobe cycle
//  hold       : stall in EX
//  pc_inc     : one pulse per accepted ROM byte
//  pc_load, pc_target, stk_push, stk_pop : PC/stack control, only alongside exec_valid
module leg4_fetch_decode
  import leg4_fetch_decode_pkg::*;
#(
  parameter int unsigned PC_W        = 12,
  parameter bit          TEST_ACT_LO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  leg4_fetch_decode_if.master bus,
  input  logic [PC_W-1:0]     pc,
  input  logic                acc_zero,
  input  logic                carry,
  input  logic                test_n,
  input  logic                reg_inc_nz,
  input  logic [7:0]          pair_val,
  input  logic                hold,
  output logic                pc_inc,
  output logic                pc_load,
  output logic [PC_W-1:0]     pc_target,
  output logic                stk_push,
  output logic                stk_pop
);

  state_e     state_q, state_d;
  logic [7:0] byte1_q;
  logic [7:0] byte2_q;
  logic       first_q;   // set for the first cycle spent in EX
  logic       accept;
  logic       exec;
  logic       jcn_take;

  logic [3:0]      opr;
  logic [3:0]      opa_f;
  logic [PC_W-9:0] page;
  logic            take;
  logic [PC_W-1:0] target;
  logic            push;
  logic            pop;

  logic unused_pc_lo;
  assign unused_pc_lo = ^pc[7:0];

  // Next state and ROM request
  always_comb begin
    state_d     = state_q;
    bus.rom_req = 1'b0;
    unique case (state_q)
      StF1: begin
        bus.rom_req = 1'b1;
        if (bus.rom_ack) state_d = is_two_byte(bus.rom_data) ? StF2 : StEx;
      end
      StF2: begin
        bus.rom_req = 1'b1;
        if (bus.rom_ack) state_d = StEx;
      end
      StEx: begin
        if (!hold) state_d = StF1;
      end
      default: state_d = StF1;
    endcase
  end

  // A byte taken during the reset cycle would be lost anyway, so do not advance the PC
  assign accept = bus.rom_req & bus.rom_ack & ~rst;
  assign pc_inc = accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StF1;
      byte1_q <= 8'h00;
      byte2_q <= 8'h00;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StF1 && bus.rom_ack) begin
        byte1_q <= bus.rom_data;
        byte2_q <= 8'h00;  // 1-byte ops report byte2 as zero
      end
      if (state_q == StF2 && bus.rom_ack) byte2_q <= bus.rom_data;
      first_q <= (state_d == StEx) && (state_q != StEx);
    end
  end

  assign exec           = (state_q == StEx) & first_q & ~rst;
  assign bus.exec_valid = exec;
  assign bus.alu_op     = byte1_q[7:4];
  assign bus.opa        = byte1_q[3:0];
  assign bus.byte2      = byte2_q;

  leg4_jcn_cond #(
    .TEST_ACT_LO (TEST_ACT_LO)
  ) u_jcn_cond (
    .opa      (byte1_q[3:0]),
    .acc_zero (acc_zero),
    .carry    (carry),
    .test_n   (test_n),
    .take     (jcn_take)
  );

  // Branch / stack decode; only meaningful while exec is high
  always_comb begin
    opr    = byte1_q[7:4];
    opa_f  = byte1_q[3:0];
    page   = pc[PC_W-1:8];
    take   = 1'b0;
    target = '0;
    push   = 1'b0;
    pop    = 1'b0;
    case (opr)
      OprJun: begin
        take   = 1'b1;
        target = PC_W'({opa_f, byte2_q});
      end
      OprJms: begin
        take   = 1'b1;
        push   = 1'b1;
        target = PC_W'({opa_f, byte2_q});
      end
      OprJcn: begin
        take   = jcn_take;
        target = {page, byte2_q};
      end
      OprIsz: begin
        take   = reg_inc_nz;
        target = {page, byte2_q};
      end
      OprFin: begin
        if (opa_f[0]) begin
          take   = 1'b1;
          target = {page, pair_val};
        end
      end
      OprBbl:  pop = 1'b1;
      default: ;
    endcase
  end

  assign pc_load   = exec & take;
  assign pc_target = (exec & take) ? target : '0;
  assign stk_push  = exec & push;
  assign stk_pop   = exec & pop;

endmodule

// File: tb/tb_leg4_fetch_decode.sv
module tb_leg4_fetch_decode;

  logic        clk;
  logic        rst;
  logic [11:0] pc;
  logic        acc_zero, carry, test_n, reg_inc_nz, hold;
  logic [7:0]  pair_val;
  logic        pc_inc, pc_load, stk_push, stk_pop;
  logic [11:0] pc_target;

  int checks;
  int failures;

  // Per-instruction observations
  int          ex_cnt, inc_cnt, req_bad, stray_cnt;
  logic [3:0]  cap_op, cap_opa;
  logic [7:0]  cap_b2;
  logic        cap_load, cap_push, cap_pop;
  logic [11:0] cap_tgt;

  leg4_fetch_decode_if bus ();

  leg4_fetch_decode #(
    .PC_W        (12),
    .TEST_ACT_LO (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .pc         (pc),
    .acc_zero   (acc_zero),
    .carry      (carry),
    .test_n     (test_n),
    .reg_inc_nz (reg_inc_nz),
    .pair_val   (pair_val),
    .hold       (hold),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .stk_push   (stk_push),
    .stk_pop    (stk_pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    ex_cnt = 0; inc_cnt = 0; req_bad = 0; stray_cnt = 0;
    cap_op = 'x; cap_opa = 'x; cap_b2 = 'x;
    cap_load = 'x; cap_push = 'x; cap_pop = 'x; cap_tgt = 'x;
  endtask

  // One clock: sample at negedge, then move to 1 time unit past the next posedge
  task automatic step(input bit in_fetch, input bit in_ex);
    @(negedge clk);
    if (bus.exec_valid === 1'b1) begin
      ex_cnt++;
      cap_op = bus.alu_op; cap_opa = bus.opa; cap_b2 = bus.byte2;
      cap_load = pc_load; cap_tgt = pc_target; cap_push = stk_push; cap_pop = stk_pop;
    end else if (pc_load !== 1'b0 || stk_push !== 1'b0 || stk_pop !== 1'b0 ||
                 pc_target !== 12'h000) begin
      stray_cnt++;
    end
    if (pc_inc === 1'b1) inc_cnt++;
    if (in_fetch && bus.rom_req !== 1'b1) req_bad++;
    if (in_ex && bus.rom_req !== 1'b0) req_bad++;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour, written from the instruction-set rules
  function automatic void model(input logic [7:0] b1, input logic [7:0] b2,
                                input int pcv, input bit az, input bit cy, input bit tn,
                                input bit inz, input logic [7:0] pv,
                                output bit two, output bit load, output int tgt,
                                output bit push, output bit pop);
    int opr, o, page;
    bit t;
    opr  = int'(b1) / 16;
    o    = int'(b1) % 16;
    page = pcv / 256;
    two  = (opr == 1) || (opr == 2 && o % 2 == 0) || (opr == 4) || (opr == 5) || (opr == 7);
    load = 0; tgt = 0; push = 0; pop = 0;
    if (opr == 4 || opr == 5) begin
      load = 1; tgt = o * 256 + int'(b2); push = (opr == 5);
    end else if (opr == 1) begin
      t    = ((o / 4) % 2 == 1 && az) || ((o / 2) % 2 == 1 && cy) || (o % 2 == 1 && !tn);
      load = (o >= 8) != t;
      tgt  = page * 256 + int'(b2);
    end else if (opr == 7) begin
      load = inz; tgt = page * 256 + int'(b2);
    end else if (opr == 3 && o % 2 == 1) begin
      load = 1; tgt = page * 256 + int'(pv);
    end else if (opr == 12) begin
      pop = 1;
    end
    if (!load) tgt = 0;
  endfunction

  task automatic run_instr(input string name, input logic [7:0] b1, input logic [7:0] b2,
                           input int d1, input int d2, input int hc, input int pcv,
                           input bit az, input bit cy, input bit tn, input bit inz,
                           input logic [7:0] pv);
    bit two, load, push, pop;
    int tgt;
    model(b1, b2, pcv, az, cy, tn, inz, pv, two, load, tgt, push, pop);
    clear_obs();
    hold = 1'b0;
    bus.rom_ack = 1'b0;
    for (int i = 0; i < d1; i++) begin
      bus.rom_data = 8'($urandom);
      step(1, 0);
    end
    bus.rom_data = b1; bus.rom_ack = 1'b1;
    step(1, 0);
    if (two) begin
      bus.rom_ack = 1'b0;
      for (int i = 0; i < d2; i++) begin
        bus.rom_data = 8'($urandom);
        step(1, 0);
      end
      bus.rom_data = b2; bus.rom_ack = 1'b1;
      step(1, 0);
    end
    pc = 12'(pcv); acc_zero = az; carry = cy; test_n = tn; reg_inc_nz = inz; pair_val = pv;
    for (int k = 0; k <= hc; k++) begin
      bus.rom_ack  = 1'($urandom);  // stray acks while not requesting
      bus.rom_data = 8'($urandom);
      hold = (k < hc);
      step(0, 1);
      // Branch inputs matter only in the strobe cycle
      acc_zero = 1'($urandom); carry = 1'($urandom); test_n = 1'($urandom);
      reg_inc_nz = 1'($urandom); pair_val = 8'($urandom); pc = 12'($urandom);
    end
    hold = 1'b0; bus.rom_ack = 1'b0;
    chk({name, ".exec_cnt"}, ex_cnt, 1);
    chk({name, ".pc_inc_cnt"}, inc_cnt, two ? 2 : 1);
    chk({name, ".rom_req"}, req_bad, 0);
    chk({name, ".stray_ctl"}, stray_cnt, 0);
    chk({name, ".alu_op"}, cap_op, b1[7:4]);
    chk({name, ".opa"}, cap_opa, b1[3:0]);
    chk({name, ".byte2"}, cap_b2, two ? b2 : 8'h00);
    chk({name, ".pc_load"}, cap_load, load);
    chk({name, ".pc_target"}, cap_tgt, tgt);
    chk({name, ".stk_push"}, cap_push, push);
    chk({name, ".stk_pop"}, cap_pop, pop);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; hold = 1'b0; pc = 12'h000;
    acc_zero = 1'b0; carry = 1'b0; test_n = 1'b1; reg_inc_nz = 1'b0; pair_val = 8'h00;
    bus.rom_ack = 1'b0; bus.rom_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset.rom_req", bus.rom_req, 1);
    chk("reset.exec_valid", bus.exec_valid, 0);
    chk("reset.pc_inc", pc_inc, 0);
    chk("reset.alu_op", bus.alu_op, 0);
    chk("reset.opa", bus.opa, 0);
    chk("reset.byte2", bus.byte2, 0);
    chk("reset.pc_load", pc_load, 0);
    chk("reset.pc_target", pc_target, 0);
    chk("reset.stk", {stk_push, stk_pop}, 0);
    @(posedge clk);
    #1;

    // Directed instructions
    run_instr("ldm", 8'hD5, 8'h00, 0, 0, 0, 12'h010, 0, 0, 1, 0, 8'h00);
    run_instr("jun", 8'h4A, 8'h23, 0, 0, 0, 12'h100, 0, 0, 1, 0, 8'h00);
    run_instr("jcn_take", 8'h14, 8'h80, 0, 0, 0, 12'h312, 1, 0, 1, 0, 8'h00);
    run_instr("jcn_inv", 8'h1C, 8'h80, 0, 0, 0, 12'h312, 1, 0, 1, 0, 8'h00);
    run_instr("jcn_test", 8'h11, 8'h44, 0, 0, 0, 12'h7F0, 0, 0, 0, 0, 8'h00);
    run_instr("jms", 8'h51, 8'h00, 0, 0, 0, 12'h200, 0, 0, 1, 0, 8'h00);
    run_instr("bbl", 8'hC3, 8'h00, 0, 0, 0, 12'h102, 0, 0, 1, 0, 8'h00);
    run_instr("isz", 8'h72, 8'h9A, 0, 0, 0, 12'h5A0, 0, 0, 1, 1, 8'h00);
    run_instr("jin", 8'h35, 8'h00, 0, 0, 0, 12'hB20, 0, 0, 1, 0, 8'h6C);
    run_instr("src", 8'h21, 8'h00, 0, 0, 0, 12'h040, 0, 0, 1, 0, 8'h00);
    run_instr("f2_wait", 8'h4A, 8'h23, 1, 5, 0, 12'h000, 0, 0, 1, 0, 8'h00);
    run_instr("hold3", 8'hE9, 8'h00, 0, 0, 3, 12'h000, 0, 0, 1, 0, 8'h00);

    // Reset while in F2: the partial JUN is discarded and an ack in the reset cycle is dropped
    clear_obs();
    bus.rom_data = 8'h40; bus.rom_ack = 1'b1;
    step(1, 0);
    rst = 1'b1; bus.rom_data = 8'hFF; bus.rom_ack = 1'b1;
    clear_obs();
    step(1, 0);
    chk("rst_f2.pc_inc", inc_cnt, 0);
    rst = 1'b0; bus.rom_ack = 1'b0;
    clear_obs();
    repeat (3) step(1, 0);
    chk("rst_f2.exec_cnt", ex_cnt, 0);
    chk("rst_f2.rom_req", req_bad, 0);
    run_instr("after_rst", 8'hD7, 8'h00, 0, 0, 0, 12'h000, 0, 0, 1, 0, 8'h00);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      run_instr("rand", 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 4095)), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
